// File: rtl/fpu_pkg.sv
`default_nettype none
//==============================================================================
// Package : fpu_pkg
// Shared FPU field widths, operator codes, FSM states and unpack helper.
// Rev     : 1.0
//==============================================================================
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;
    localparam int RAW_W    = 48;
    localparam int EXP_BIAS = 127;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_MUL   = 3'd3,
        ST_DONE  = 3'd4
    } fpu_state_e;

    // Zero exponent means zero operand: denormals are flushed, hidden bit 0.
    function automatic logic [MANT_W-1:0] unpack_mant(input logic [31:0] f);
        return (f[FRAC_W +: EXP_W] == '0) ? '0 : {1'b1, f[FRAC_W-1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_seq_multiplier.sv
`default_nettype none
//==============================================================================
// Module : fpu_seq_multiplier
// Iterative 24x24 shift-add multiplier retiring MUL_BITS_PER_CYCLE bits/cycle.
// Rev    : 1.0
//==============================================================================
module fpu_seq_multiplier
    import fpu_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [MANT_W-1:0] i_multiplicand,
    input  logic [MANT_W-1:0] i_multiplier,
    output logic              o_done,
    output logic [RAW_W-1:0]  o_product
);

    localparam int MUL_CYCLES = MANT_W / MUL_BITS_PER_CYCLE;

    logic              r_busy;
    logic [4:0]        r_count;
    logic [RAW_W-1:0]  r_mcand;
    logic [MANT_W-1:0] r_mplier;
    logic [RAW_W-1:0]  r_acc;
    logic [RAW_W-1:0]  w_acc_next;

    always_comb begin
        w_acc_next = r_acc;
        for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
            if (r_mplier[j]) begin
                w_acc_next = w_acc_next + (r_mcand << j);
            end
        end
    end

    // Done and product are combinational so the caller can capture the
    // final partial sum on the same edge as the last iteration.
    assign o_done    = r_busy && (r_count == 5'(MUL_CYCLES - 1));
    assign o_product = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_count  <= '0;
            r_mcand  <= {{(RAW_W-MANT_W){1'b0}}, i_multiplicand};
            r_mplier <= i_multiplier;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << MUL_BITS_PER_CYCLE;
            r_mplier <= r_mplier >> MUL_BITS_PER_CYCLE;
            r_count  <= r_count + 5'd1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_unpack_align.sv
`default_nettype none
//==============================================================================
// Module : fpu_unpack_align
// FPU front end: unpacks operands, aligns and adds or multiplies mantissas.
// Rev    : 1.0
//==============================================================================
module fpu_unpack_align
    import fpu_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [1:0]       in_operator,
    output logic             out_valid,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exponent,
    output logic [RAW_W-1:0] out_mantissa,
    output logic [1:0]       out_operator
);

    fpu_state_e        r_state;
    logic              r_sign_a, r_sign_b;
    logic [EXP_W-1:0]  r_exp_a, r_exp_b;
    logic [MANT_W-1:0] r_mant_a, r_mant_b;
    logic [1:0]        r_op;

    logic              r_big_sign, r_small_sign;
    logic [EXP_W-1:0]  r_big_exp;
    logic [MANT_W-1:0] r_big_mant, r_small_mant;

    logic              w_accept;
    logic [MANT_W-1:0] w_in_mant_a, w_in_mant_b;
    logic              w_mul_done;
    logic [RAW_W-1:0]  w_mul_product;

    assign in_ready    = (r_state == ST_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_in_mant_a = unpack_mant(in_a);
    assign w_in_mant_b = unpack_mant(in_b);

    fpu_seq_multiplier #(
        .MUL_BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (w_accept && (in_operator == OP_MUL)),
        .i_multiplicand (w_in_mant_a),
        .i_multiplier   (w_in_mant_b),
        .o_done         (w_mul_done),
        .o_product      (w_mul_product)
    );

    // Alignment: larger magnitude (exponent, then mantissa) becomes A.
    logic              w_swap;
    logic              w_big_sign, w_small_sign;
    logic [EXP_W-1:0]  w_big_exp, w_small_exp, w_exp_diff;
    logic [MANT_W-1:0] w_big_mant, w_small_mant, w_small_aligned;

    assign w_swap          = {r_exp_b, r_mant_b} > {r_exp_a, r_mant_a};
    assign w_big_sign      = w_swap ? r_sign_b : r_sign_a;
    assign w_small_sign    = w_swap ? r_sign_a : r_sign_b;
    assign w_big_exp       = w_swap ? r_exp_b  : r_exp_a;
    assign w_small_exp     = w_swap ? r_exp_a  : r_exp_b;
    assign w_big_mant      = w_swap ? r_mant_b : r_mant_a;
    assign w_small_mant    = w_swap ? r_mant_a : r_mant_b;
    assign w_exp_diff      = w_big_exp - w_small_exp;
    assign w_small_aligned = (w_exp_diff >= 8'd24) ? '0 : (w_small_mant >> w_exp_diff);

    logic              w_same_sign;
    logic [MANT_W:0]   w_sum;
    logic              w_add_sign;

    assign w_same_sign = (r_big_sign == r_small_sign);
    assign w_sum       = w_same_sign ? ({1'b0, r_big_mant} + {1'b0, r_small_mant})
                                     : ({1'b0, r_big_mant} - {1'b0, r_small_mant});
    assign w_add_sign  = (!w_same_sign && (w_sum == '0)) ? 1'b0 : r_big_sign;

    logic signed [9:0] w_mul_exp_sum;
    logic              w_mul_zero, w_mul_ovf;

    assign w_mul_exp_sum = $signed({2'b00, r_exp_a}) + $signed({2'b00, r_exp_b})
                         - $signed(10'(EXP_BIAS));
    assign w_mul_zero    = (r_exp_a == '0) || (r_exp_b == '0) || (w_mul_exp_sum <= 10'sd0);
    assign w_mul_ovf     = (w_mul_exp_sum >= 10'sd255);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sign_a     <= 1'b0;
            r_sign_b     <= 1'b0;
            r_exp_a      <= '0;
            r_exp_b      <= '0;
            r_mant_a     <= '0;
            r_mant_b     <= '0;
            r_op         <= '0;
            r_big_sign   <= 1'b0;
            r_small_sign <= 1'b0;
            r_big_exp    <= '0;
            r_big_mant   <= '0;
            r_small_mant <= '0;
            out_valid    <= 1'b0;
            out_sign     <= 1'b0;
            out_exponent <= '0;
            out_mantissa <= '0;
            out_operator <= '0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sign_a <= in_a[EXP_W+FRAC_W];
                        r_sign_b <= in_b[EXP_W+FRAC_W] ^ (in_operator == OP_SUB);
                        r_exp_a  <= in_a[FRAC_W +: EXP_W];
                        r_exp_b  <= in_b[FRAC_W +: EXP_W];
                        r_mant_a <= w_in_mant_a;
                        r_mant_b <= w_in_mant_b;
                        r_op     <= in_operator;
                        r_state  <= (in_operator == OP_MUL) ? ST_MUL : ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    r_big_sign   <= w_big_sign;
                    r_small_sign <= w_small_sign;
                    r_big_exp    <= w_big_exp;
                    r_big_mant   <= w_big_mant;
                    r_small_mant <= w_small_aligned;
                    r_state      <= ST_ADD;
                end
                ST_ADD: begin
                    out_valid <= 1'b1;
                    r_state   <= ST_DONE;
                    if (r_op == OP_NONE) begin
                        out_sign     <= 1'b0;
                        out_exponent <= '0;
                        out_mantissa <= '0;
                        out_operator <= OP_NONE;
                    end else begin
                        out_sign     <= w_add_sign;
                        out_exponent <= r_big_exp;
                        out_mantissa <= {{(RAW_W-MANT_W-1){1'b0}}, w_sum};
                        out_operator <= OP_ADD;
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        out_valid    <= 1'b1;
                        out_sign     <= r_sign_a ^ r_sign_b;
                        out_operator <= OP_MUL;
                        r_state      <= ST_DONE;
                        if (w_mul_zero) begin
                            out_exponent <= '0;
                            out_mantissa <= '0;
                        end else if (w_mul_ovf) begin
                            out_exponent <= 8'hFF;
                            out_mantissa <= '0;
                        end else begin
                            out_exponent <= w_mul_exp_sum[EXP_W-1:0];
                            out_mantissa <= w_mul_product;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_unpack_align.sv
`default_nettype none
//==============================================================================
// Module : tb_fpu_unpack_align
// Randomised bench for fpu_unpack_align against an arithmetic reference model.
// Rev    : 1.0
//==============================================================================
module tb_fpu_unpack_align;

    localparam int BPC        = 1;
    localparam int MUL_CYCLES = 24 / BPC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [1:0]  in_operator = '0;
    logic        out_valid;
    logic        out_sign;
    logic [7:0]  out_exponent;
    logic [47:0] out_mantissa;
    logic [1:0]  out_operator;

    fpu_unpack_align #(.MUL_BITS_PER_CYCLE(BPC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_operator  (in_operator),
        .out_valid    (out_valid),
        .out_sign     (out_sign),
        .out_exponent (out_exponent),
        .out_mantissa (out_mantissa),
        .out_operator (out_operator)
    );

    always #5 clk = ~clk;

    int n = 0;
    always @(posedge clk) n <= n + 1;

    typedef struct {
        int          due;
        logic        sign;
        logic [7:0]  exp;
        logic [47:0] mant;
        logic [1:0]  op;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   next_free = 0;
    bit   in_rst = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: works on magnitudes as integers, independent of the FSM.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        res_t   r;
        longint ma, mb, m, t;
        int     ea, eb, e, d;
        logic   sa, sb, ts;
        r.due = 0; r.sign = 0; r.exp = 0; r.mant = 0; r.op = op;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (ea == 0) ? 64'd0 : (longint'(1) << 23) + longint'(a[22:0]);
        mb = (eb == 0) ? 64'd0 : (longint'(1) << 23) + longint'(b[22:0]);
        sa = a[31];
        sb = b[31];
        if (op == 2'b11) begin
            r.op = 2'b11;
        end else if (op == 2'b10) begin
            e = ea + eb - 127;
            r.sign = sa ^ sb;
            if (ea == 0 || eb == 0 || e <= 0) begin
                r.exp = 8'd0;
            end else if (e >= 255) begin
                r.exp = 8'd255;
            end else begin
                r.exp  = 8'(e);
                r.mant = 48'(ma * mb);
            end
        end else begin
            if (op == 2'b01) sb = ~sb;
            if (eb * 64'd16777216 + mb > ea * 64'd16777216 + ma) begin
                t = ma; ma = mb; mb = t;
                d = ea; ea = eb; eb = d;
                ts = sa; sa = sb; sb = ts;
            end
            d  = ea - eb;
            mb = (d >= 24) ? 64'd0 : (mb >> d);
            m  = (sa == sb) ? ma + mb : ma - mb;
            r.sign = (sa != sb && m == 0) ? 1'b0 : sa;
            r.exp  = 8'(ea);
            r.mant = 48'(m);
            r.op   = 2'b00;
        end
        return r;
    endfunction

    // Single compare process: out_valid, in_ready and result fields each cycle.
    always @(negedge clk) begin
        bit   want;
        res_t e;
        if (!in_rst) begin
            want = (exp_q.size() > 0) && (exp_q[0].due == n);
            check("out_valid", out_valid, want);
            check("in_ready", in_ready, n >= next_free - 1);
            if (want) begin
                e = exp_q.pop_front();
                check("out_sign", out_sign, e.sign);
                check("out_exponent", out_exponent, e.exp);
                check("out_mantissa", out_mantissa, e.mant);
                check("out_operator", out_operator, e.op);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        res_t e;
        int   lat;
        while (n + 1 < next_free) begin
            in_valid    = 1'b1;
            in_a        = $urandom;
            in_b        = $urandom;
            in_operator = 2'($urandom);
            @(negedge clk);
        end
        in_valid    = 1'b1;
        in_a        = a;
        in_b        = b;
        in_operator = op;
        @(posedge clk);
        #1;
        e = model(a, b, op);
        lat = (op == 2'b10) ? MUL_CYCLES + 1 : 3;
        e.due = n + lat - 1;
        exp_q.push_back(e);
        next_free = n + lat + 1;
        @(negedge clk);
        in_a     = $urandom;
        in_b     = $urandom;
        in_valid = 1'($urandom);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            if (n + 1 >= next_free) in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 8)
            0: r[30:23] = 8'd0;
            1: r[30:23] = 8'd127 + 8'($urandom % 8);
            2: r[30:23] = 8'd254;
            3: r[30:23] = 8'd1 + 8'($urandom % 4);
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        res_t        p;
        logic [31:0] a, b;
        logic [1:0]  op;

        p = model(32'h3FC00000, 32'h40200000, 2'b00);
        check("pin_add_mant", p.mant, 48'h000001000000);
        check("pin_add_exp", p.exp, 8'h80);
        p = model(32'h40400000, 32'h40400000, 2'b01);
        check("pin_sub_zero", {p.sign, p.mant}, 49'd0);
        p = model(32'h40000000, 32'h40400000, 2'b10);
        check("pin_mul", {p.exp, p.mant}, {8'h81, 48'h600000000000});
        p = model(32'h3F800000, 32'h30800000, 2'b00);
        check("pin_gap", {p.exp, p.mant}, {8'h7F, 48'h000000800000});
        p = model(32'h00000000, 32'h40400000, 2'b10);
        check("pin_mul_zero", {p.exp, p.mant}, 56'd0);

        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_fields", {out_sign, out_exponent, out_mantissa, out_operator}, 59'd0);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        @(negedge clk);

        issue(32'h3FC00000, 32'h40200000, 2'b00);
        issue(32'h40400000, 32'h40400000, 2'b01);
        issue(32'h40000000, 32'h40400000, 2'b10);
        issue(32'h3F800000, 32'h30800000, 2'b00);
        issue(32'h00000000, 32'h40400000, 2'b10);
        issue(32'hC0A00000, 32'h40A00000, 2'b00);
        issue(32'h12345678, 32'h9ABCDEF0, 2'b11);
        issue(32'h7F000000, 32'h7F000000, 2'b10);
        drain();

        for (int i = 0; i < 40; i++) begin
            idle($urandom % 3);
            a  = rand_fp();
            b  = rand_fp();
            op = 2'($urandom);
            case ($urandom % 6)
                0: b = a;
                1: b = {~a[31], a[30:0]};
                2: b[30:23] = a[30:23];
                default: ;
            endcase
            issue(a, b, op);
        end
        drain();

        // Abort a multiply mid-flight; no result may appear for it.
        issue(32'h40000000, 32'h40400000, 2'b10);
        repeat (9) @(negedge clk);
        in_valid = 1'b0;
        in_rst   = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_fields", {out_sign, out_exponent, out_mantissa, out_operator}, 59'd0);
        check("midrst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        next_free = 0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_hold_valid", out_valid, 1'b0);
        end
        rst_n  = 1'b1;
        in_rst = 1'b0;
        idle(MUL_CYCLES + 4);
        issue(32'h3FC00000, 32'h40200000, 2'b00);
        drain();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fpu_unpack_align.md
# fpu_unpack_align

Front-end operand stage of the FPU. Accepts two IEEE-754 single-precision operands and an operator through a valid/ready handshake. Unpacks the fields, restores hidden bits, and aligns and adds the mantissas, or multiplies them with an iterative shift-add multiplier. It presents sign, biased exponent and a 48-bit raw mantissa in exactly the format `fpu_normalize` consumes on its `in_*` ports.

## Interface
Parameters:
- `MUL_BITS_PER_CYCLE`, default 1: multiplier bits retired per cycle. Legal values are 1, 2, 3, 4, 6, 8. `MUL_CYCLES` = 24 / `MUL_BITS_PER_CYCLE`.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand pair present
- `in_ready`  out  1  block can accept; combinational, equals (state == IDLE)
- `in_a`  in  32  operand A, IEEE-754 single
- `in_b`  in  32  operand B, IEEE-754 single
- `in_operator`  in  2  00 add, 01 sub, 10 mul, 11 unsupported
- `out_valid`  out  1  one-cycle pulse: result fields valid
- `out_sign`  out  1  result sign
- `out_exponent`  out  8  biased exponent before normalization
- `out_mantissa`  out  48  raw mantissa. Add/sub: sum in [24:0], [47:25]=0. Mul: full 48-bit product.
- `out_operator`  out  2  00 for add/sub, 10 for mul, 11 passthrough

## Operation
- Handshake: a transfer occurs when `in_valid && in_ready` on a rising edge. Operands are captured into internal registers, so inputs may change afterwards.
- Unpack: an exponent field of 0 means the operand is zero. No denormals: mantissa is 0 and the hidden bit is 0. Otherwise the 24-bit mantissa is {1, frac}. Inf/NaN are not special-cased.
- Sub: B's sign is inverted and the add path is used; `out_operator`=00.
- FSM states: IDLE, ALIGN, ADD, MUL, DONE.
  - IDLE → ALIGN on accept when the operator is 00, 01 or 11.
  - IDLE → MUL on accept when the operator is 10.
- ALIGN: swap operands so A has the larger magnitude (exponent first, then mantissa). Shift B's mantissa right by the exponent difference. A difference ≥ 24 yields 0. Truncate; no guard or sticky bits.
- ADD:
  - Equal signs: mantissa = mA + mB (25 bits).
  - Otherwise: mantissa = mA − mB.
  - Exponent = larger exponent; sign = sign of A.
  - An exact-zero difference forces sign 0.
  - The 11 operator skips arithmetic and outputs zeros with `out_operator`=11.
- MUL: runs `MUL_CYCLES` shift-add iterations over 24×24 mantissas, producing a 48-bit product. Sign = sA ^ sB.
  - Exponent: 10-bit signed sum eA+eB−127.
  - Sum ≤ 0, or either operand zero: exponent 0, mantissa 0.
  - Sum ≥ 255: exponent 255, mantissa 0.
- DONE: output registers are loaded and `out_valid`=1 for one cycle; next state is IDLE.
- Outputs hold their last value until the next DONE.

## Timing
- Reset (async assert): state IDLE; `out_valid`=0; `out_sign`=0, `out_exponent`=0, `out_mantissa`=0, `out_operator`=0.
- `in_ready`=1 while in reset, because the state is IDLE.
- Reset mid-operation aborts the operation; no `out_valid` is produced for it.
- Accept edge = t.
  - Add/sub/11: ALIGN at t+1, ADD at t+2, `out_valid` high at t+3.
  - Mul: MUL during t+1 … t+`MUL_CYCLES`, `out_valid` at t+`MUL_CYCLES`+1 (t+25 by default).
- Latency is fixed and data-independent, including zero operands.
- `in_ready` is low from t+1 through the DONE cycle. A new accept is possible on the first IDLE cycle after DONE.
- Throughput: one operation per 4 cycles for add, or per `MUL_CYCLES`+2 cycles for mul.

## Structure
- Shared package `fpu_pkg`:
  - operator codes `OP_ADD`, `OP_SUB`, `OP_MUL`
  - `EXP_BIAS`=127
  - field widths: `EXP_W`=8, `FRAC_W`=23, `MANT_W`=24, `RAW_W`=48
  - FSM state enum
- Sub-module `fpu_seq_multiplier`: start/done handshake, 24×24 iterative shift-add, parameterized by `MUL_BITS_PER_CYCLE`.

## Test plan
- Add: `in_a`=0x3FC00000 (1.5), `in_b`=0x40200000 (2.5), op 00 → at t+3: `out_sign`=0, `out_exponent`=0x80, `out_mantissa`=0x000001000000, `out_operator`=00.
- Sub to zero: 0x40400000 − 0x40400000, op 01 → at t+3: mantissa 0, sign 0, exponent 0x80.
- Mul: 0x40000000 (2.0) × 0x40400000 (3.0), op 10 → at t+25: sign 0, exponent 0x81, mantissa 0x600000000000, `out_operator`=10.
- Large exponent gap: 0x3F800000 + 0x30800000 (diff 30) → mantissa 0x000000800000, exponent 0x7F. Then 0x00000000 × 0x40400000 → at t+25: exponent 0, mantissa 0.
- Handshake and reset:
  - Hold `in_valid`=1 across back-to-back ops → `in_ready` is low t+1..t+3, and the second op is accepted at t+4.
  - Assert `rst_n`=0 during MUL cycle 10 → all outputs 0 and no `out_valid` pulse.
  - After reset, the next add completes correctly.
